// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: LSL / LSR / ASR / ROL with valid/ready flow control.
// Define BARREL_STICKY_EN to add the Sticky output (OR of bits lost past the LSB).
module pipelined_barrel_shifter #(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [N-1:0]         In,
  input  logic [$clog2(N)-1:0] ShiftAmount,
  input  logic [1:0]           Mode,
  input  logic                 ShiftIn,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [N-1:0]         Out
`ifdef BARREL_STICKY_EN
  ,
  output logic                 Sticky
`endif
);

  localparam int W = $clog2(N);
  localparam int G = (W + STAGES - 1) / STAGES;

  logic [N-1:0] data_r  [STAGES];
  logic [W-1:0] amt_r   [STAGES];
  logic [1:0]   mode_r  [STAGES];
  logic         fill_r  [STAGES];
  logic         sign_r  [STAGES];
  logic         valid_r [STAGES];

  logic [N-1:0] data_s  [STAGES];
  logic [W-1:0] amt_s   [STAGES];
  logic [1:0]   mode_s  [STAGES];
  logic         fill_s  [STAGES];
  logic         sign_s  [STAGES];
  logic         valid_s [STAGES];

`ifdef BARREL_STICKY_EN
  logic         sticky_r [STAGES];
  logic         sticky_s [STAGES];
`endif

  logic         advance_s;

  // One mux level: shift by 2^k with the fill bit chosen by the mode.
  function automatic logic [N-1:0] shift_level(input logic [N-1:0] d, input int k,
                                               input logic [1:0] mode, input logic fill,
                                               input logic sign);
    logic [N-1:0] r;
    logic [W-1:0] idx_l;
    logic [W-1:0] idx_r;
    int           sh;
    r  = '0;
    sh = 1 << k;
    for (int i = 0; i < N; i++) begin
      idx_l = W'(i - sh);
      idx_r = W'(i + sh);
      case (mode)
        2'b00:   r[i] = (i >= sh) ? d[idx_l] : fill;
        2'b01:   r[i] = (i + sh < N) ? d[idx_r] : fill;
        2'b10:   r[i] = (i + sh < N) ? d[idx_r] : sign;
        2'b11:   r[i] = d[idx_l];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // OR of the 2^k low bits that a right shift at level k drops.
  function automatic logic lost_bits(input logic [N-1:0] d, input int k);
    logic l;
    l = 1'b0;
    for (int i = 0; i < N; i++) begin
      l = l | ((i < (1 << k)) ? d[i] : 1'b0);
    end
    return l;
  endfunction

  assign advance_s = !OutValid || OutReady;
  assign InReady   = advance_s;
  assign Out       = data_r[STAGES-1];
  assign OutValid  = valid_r[STAGES-1];
`ifdef BARREL_STICKY_EN
  assign Sticky    = sticky_r[STAGES-1];
`endif

  // Next-state of every stage: take the predecessor, then apply this group's levels (MSB level first).
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        data_s[s]  = In;
        amt_s[s]   = ShiftAmount;
        mode_s[s]  = Mode;
        fill_s[s]  = ShiftIn;
        sign_s[s]  = In[N-1];
        valid_s[s] = InValid && advance_s;
      end else begin
        data_s[s]  = data_r[s-1];
        amt_s[s]   = amt_r[s-1];
        mode_s[s]  = mode_r[s-1];
        fill_s[s]  = fill_r[s-1];
        sign_s[s]  = sign_r[s-1];
        valid_s[s] = valid_r[s-1];
      end
`ifdef BARREL_STICKY_EN
      sticky_s[s] = (s == 0) ? 1'b0 : sticky_r[s-1];
`endif
      for (int j = 0; j < W; j++) begin
        if ((j >= s * G) && (j < (s + 1) * G) && amt_s[s][W-1-j]) begin
`ifdef BARREL_STICKY_EN
          sticky_s[s] = sticky_s[s] |
                        (((mode_s[s] == 2'b01) || (mode_s[s] == 2'b10)) && lost_bits(data_s[s], W-1-j));
`endif
          data_s[s] = shift_level(data_s[s], W-1-j, mode_s[s], fill_s[s], sign_s[s]);
        end else begin
          data_s[s] = data_s[s];
        end
      end
    end
  end

  // Stage registers: cleared by reset, loaded together on advance, held otherwise.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      for (int s = 0; s < STAGES; s++) begin
        data_r[s]   <= '0;
        amt_r[s]    <= '0;
        mode_r[s]   <= 2'b00;
        fill_r[s]   <= 1'b0;
        sign_r[s]   <= 1'b0;
        valid_r[s]  <= 1'b0;
`ifdef BARREL_STICKY_EN
        sticky_r[s] <= 1'b0;
`endif
      end
    end else if (advance_s) begin
      for (int s = 0; s < STAGES; s++) begin
        data_r[s]   <= data_s[s];
        amt_r[s]    <= amt_s[s];
        mode_r[s]   <= mode_s[s];
        fill_r[s]   <= fill_s[s];
        sign_r[s]   <= sign_s[s];
        valid_r[s]  <= valid_s[s];
`ifdef BARREL_STICKY_EN
        sticky_r[s] <= sticky_s[s];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (N=8, STAGES=3).
module tb_pipelined_barrel_shifter;
  localparam int N      = 8;
  localparam int STAGES = 3;

  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [N-1:0] In = 8'h00;
  logic [2:0]   ShiftAmount = 3'd0;
  logic [1:0]   Mode = 2'b00;
  logic         ShiftIn = 1'b0;
  logic         OutValid;
  logic         OutReady = 1'b1;
  logic [N-1:0] Out;
`ifdef BARREL_STICKY_EN
  logic         Sticky;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  pipelined_barrel_shifter #(.N(N), .STAGES(STAGES)) dut (
    .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .In(In), .ShiftAmount(ShiftAmount), .Mode(Mode), .ShiftIn(ShiftIn),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out)
`ifdef BARREL_STICKY_EN
    , .Sticky(Sticky)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] amt,
                                       input logic [1:0] mode, input logic fill);
    logic [7:0] m;
    case (mode)
      2'b00:   m = (d << amt) | (fill ? ~(8'hFF << amt) : 8'h00);
      2'b01:   m = (d >> amt) | (fill ? ~(8'hFF >> amt) : 8'h00);
      2'b10:   m = $signed(d) >>> amt;
      default: m = (d << amt) | (d >> (4'd8 - {1'b0, amt}));
    endcase
    return m;
  endfunction

  task automatic drive(input logic [7:0] d, input logic [2:0] amt, input logic [1:0] mode,
                       input logic fill);
    InValid = 1'b1;
    In = d;
    ShiftAmount = amt;
    Mode = mode;
    ShiftIn = fill;
  endtask

  task automatic send_one(input string tag, input logic [7:0] d, input logic [2:0] amt,
                          input logic [1:0] mode, input logic fill, input logic [7:0] exp,
                          input logic exp_sticky);
    int n;
    OutReady = 1'b1;
    drive(d, amt, mode, fill);
    tick();
    InValid = 1'b0;
    n = 0;
    while (!OutValid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, OutValid, 1);
    check(tag, Out, exp);
`ifdef BARREL_STICKY_EN
    check({tag, "_sticky"}, Sticky, exp_sticky);
`else
    if (exp_sticky === 1'bx) $display("unused");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vin [16];
    logic [2:0] vamt [16];
    logic [1:0] vmode [16];
    logic       vfill [16];
    int sent, recv, cyc;

    // Reset state
    ResetN = 1'b0;
    tick();
    tick();
    ResetN = 1'b1;
    check("rst_outvalid", OutValid, 0);
    check("rst_out", Out, 0);
    check("rst_inready", InReady, 1);
`ifdef BARREL_STICKY_EN
    check("rst_sticky", Sticky, 0);
`endif

    // Latency: OutValid rises exactly 3 edges after acceptance
    OutReady = 1'b1;
    drive(8'b1001_0110, 3'd3, 2'b00, 1'b1);
    tick();
    InValid = 1'b0;
    check("lat_1", OutValid, 0);
    tick();
    check("lat_2", OutValid, 0);
    tick();
    check("lat_3", OutValid, 1);
    check("lat_out", Out, 8'b1011_0111);
    tick();
    check("lat_drain", OutValid, 0);

    // Directed modes and boundaries
    send_one("ar2",  8'h96, 3'd2, 2'b10, 1'b0, 8'hE5, 1'b1);
    send_one("lr2",  8'h96, 3'd2, 2'b01, 1'b0, 8'h25, 1'b1);
    send_one("rl4",  8'h96, 3'd4, 2'b11, 1'b0, 8'h69, 1'b0);
    send_one("ll0",  8'h96, 3'd0, 2'b00, 1'b1, 8'h96, 1'b0);
    send_one("lr0",  8'h96, 3'd0, 2'b01, 1'b1, 8'h96, 1'b0);
    send_one("ar0",  8'h96, 3'd0, 2'b10, 1'b0, 8'h96, 1'b0);
    send_one("rl0",  8'h96, 3'd0, 2'b11, 1'b1, 8'h96, 1'b0);
    send_one("ar7",  8'h80, 3'd7, 2'b10, 1'b0, 8'hFF, 1'b0);
    send_one("lr7",  8'h80, 3'd7, 2'b01, 1'b0, 8'h01, 1'b0);
    send_one("ll7f", 8'h01, 3'd7, 2'b00, 1'b1, 8'hFF, 1'b0);
    send_one("ar3p", 8'h70, 3'd3, 2'b10, 1'b1, 8'h0E, 1'b0);
    send_one("rl1",  8'h81, 3'd1, 2'b11, 1'b1, 8'h03, 1'b0);
    send_one("stk1", 8'h96, 3'd3, 2'b01, 1'b0, 8'h12, 1'b1);
    send_one("stk0", 8'h90, 3'd3, 2'b01, 1'b0, 8'h12, 1'b0);
    tick();

    // Stream of 16 beats with random back-pressure
    for (int i = 0; i < 16; i++) begin
      vin[i]   = 8'($urandom);
      vamt[i]  = 3'($urandom);
      vmode[i] = 2'($urandom);
      vfill[i] = 1'($urandom);
    end
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 16 && cyc < 400) begin
      if (sent < 16) drive(vin[sent], vamt[sent], vmode[sent], vfill[sent]);
      else InValid = 1'b0;
      OutReady = 1'($urandom_range(0, 1));
      #1;
      check("inready_rule", InReady, !(OutValid && !OutReady));
      if (OutValid && OutReady) begin
        check("stream_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("stream_out", Out, exp_q.pop_front());
        recv++;
      end
      if (InValid && InReady) begin
        exp_q.push_back(model(vin[sent], vamt[sent], vmode[sent], vfill[sent]));
        sent++;
      end
      tick();
      cyc++;
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    check("stream_recv", recv, 16);
    tick();
    tick();
    tick();
    check("stream_no_extra", OutValid, 0);

    // Hold under back-pressure
    OutReady = 1'b0;
    drive(8'h96, 3'd3, 2'b00, 1'b1);
    tick();
    drive(8'h96, 3'd2, 2'b10, 1'b0);
    tick();
    drive(8'h96, 3'd2, 2'b01, 1'b0);
    tick();
    drive(8'hFF, 3'd1, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", OutValid, 1);
      check("hold_out", Out, 8'hB7);
      check("hold_inready", InReady, 0);
      tick();
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    #1;
    check("drain_a", Out, 8'hB7);
    tick();
    check("drain_b_valid", OutValid, 1);
    check("drain_b", Out, 8'hE5);
    tick();
    check("drain_c_valid", OutValid, 1);
    check("drain_c", Out, 8'h25);
    tick();
    check("drain_end", OutValid, 0);

    // Reset with beats in flight plus one offered in the reset cycle
    drive(8'h96, 3'd3, 2'b00, 1'b1);
    tick();
    drive(8'h96, 3'd4, 2'b11, 1'b0);
    tick();
    drive(8'h55, 3'd1, 2'b00, 1'b0);
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    InValid = 1'b0;
    check("mrst_valid", OutValid, 0);
    check("mrst_inready", InReady, 1);
    check("mrst_out", Out, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_no_emerge", OutValid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
